// File: rtl/adder_pkg.sv
// Constants shared by the adder family.
package adder_pkg;

    localparam int unsigned DEFAULT_ADDER_WIDTH = 4;

endpackage

// File: rtl/full_adder.sv
// One-bit full adder: the leaf cell of the ripple chain.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder with one register stage: {Cout, Sum} = A + B + Cin.
// Ovf flags signed overflow as carry-into-MSB xor carry-out-of-MSB.
module ripple_carry_adder
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_ADDER_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum_d, sum_q;
    logic             cout_d, cout_q;
    logic             ovf_d, ovf_q;
    logic             valid_q;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (A[i]),
            .b    (B[i]),
            .cin  (c[i]),
            .s    (sum_d[i]),
            .cout (c[i+1])
        );
    end

    // For WIDTH = 1, c[WIDTH-1] is c[0], i.e. Cin.
    assign cout_d = c[WIDTH];
    assign ovf_d  = c[WIDTH] ^ c[WIDTH-1];

    // Result registers only load on in_valid, so X on idle inputs never propagates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign Sum       = sum_q;
    assign Cout      = cout_q;
    assign Ovf       = ovf_q;
    assign out_valid = valid_q;

endmodule

// File: tb/tb_ripple_carry_adder.sv
// Self-checking bench for ripple_carry_adder (WIDTH = 4 exhaustive, plus a WIDTH = 8 instance).
module tb_ripple_carry_adder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a, b;
    logic       cin;
    logic [3:0] sum;
    logic       cout, ovf, out_valid;

    logic       in_valid8;
    logic [7:0] a8, b8;
    logic       cin8;
    logic [7:0] sum8;
    logic       cout8, ovf8, out_valid8;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       valid;
        logic       ovf;
        logic       cout;
        logic [3:0] sum;
    } exp_t;

    exp_t sb_q[$];
    exp_t held;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .A         (a),
        .B         (b),
        .Cin       (cin),
        .Sum       (sum),
        .Cout      (cout),
        .Ovf       (ovf),
        .out_valid (out_valid)
    );

    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid8),
        .A         (a8),
        .B         (b8),
        .Cin       (cin8),
        .Sum       (sum8),
        .Cout      (cout8),
        .Ovf       (ovf8),
        .out_valid (out_valid8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Signed overflow: operands share a sign that the result does not.
    function automatic exp_t model(input logic [3:0] av, input logic [3:0] bv, input logic cv);
        exp_t       e;
        logic [4:0] t;
        t       = {1'b0, av} + {1'b0, bv} + {4'b0, cv};
        e.valid = 1'b1;
        e.sum   = t[3:0];
        e.cout  = t[4];
        e.ovf   = (av[3] == bv[3]) && (t[3] != av[3]);
        return e;
    endfunction

    task automatic drive(input logic v, input logic [3:0] av, input logic [3:0] bv,
                         input logic cv, input string tag);
        exp_t e;
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = cv;
        if (v) begin
            held = model(av, bv, cv);
            sb_q.push_back(held);
        end else begin
            e       = held;
            e.valid = 1'b0;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({tag, " out_valid"}, {31'b0, out_valid}, {31'b0, e.valid});
        check({tag, " sum"},       {28'b0, sum},       {28'b0, e.sum});
        check({tag, " cout"},      {31'b0, cout},      {31'b0, e.cout});
        check({tag, " ovf"},       {31'b0, ovf},       {31'b0, e.ovf});
    endtask

    task automatic check_zero(input string tag);
        check({tag, " sum"},       {28'b0, sum},       32'h0);
        check({tag, " cout"},      {31'b0, cout},      32'h0);
        check({tag, " ovf"},       {31'b0, ovf},       32'h0);
        check({tag, " out_valid"}, {31'b0, out_valid}, 32'h0);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        in_valid8 = 1'b0;
        a8        = '0;
        b8        = '0;
        cin8      = 1'b0;
        held      = '0;

        #1;
        check_zero("reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Spot checks with hand-derived results, independent of the model.
        drive(1'b1, 4'hF, 4'h1, 1'b0, "f+1");
        check("f+1 literal", {27'b0, cout, sum}, 32'h10);
        drive(1'b1, 4'h5, 4'h3, 1'b1, "5+3+1");
        check("5+3+1 literal", {27'b0, cout, sum}, 32'h09);
        drive(1'b1, 4'hF, 4'h0, 1'b1, "ripple");
        check("ripple literal", {26'b0, ovf, cout, sum}, 32'h10);
        drive(1'b1, 4'h7, 4'h1, 1'b0, "ovf 7+1");
        check("ovf 7+1 literal", {26'b0, ovf, cout, sum}, 32'h28);
        drive(1'b1, 4'h8, 4'h8, 1'b0, "ovf 8+8");
        check("ovf 8+8 literal", {26'b0, ovf, cout, sum}, 32'h30);
        drive(1'b1, 4'hF, 4'hF, 1'b1, "all ones");
        check("all ones literal", {27'b0, cout, sum}, 32'h1F);
        drive(1'b1, 4'h0, 4'h0, 1'b0, "zeros");
        check("zeros literal", {26'b0, ovf, cout, sum}, 32'h0);

        // Exhaustive sweep, back-to-back.
        for (int i = 0; i < 512; i++) begin
            drive(1'b1, i[3:0], i[7:4], i[8], $sformatf("exh a=%0d b=%0d c=%0d", i[3:0], i[7:4], i[8]));
        end

        // Hold with X on idle inputs.
        drive(1'b1, 4'h3, 4'h4, 1'b0, "hold load");
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'hx, 4'hx, 1'bx, "hold x");
            check("hold x sum literal", {28'b0, sum}, 32'h7);
        end

        // Async reset between edges.
        drive(1'b1, 4'h7, 4'h7, 1'b0, "pre-reset");
        check("pre-reset literal", {28'b0, sum}, 32'hE);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_zero("async reset");
        held = '0;
        #1;
        rst_n = 1'b1;
        drive(1'b0, 4'h9, 4'h9, 1'b1, "post-reset idle");
        drive(1'b1, 4'h6, 4'h2, 1'b1, "post-reset");
        check("post-reset literal", {27'b0, cout, sum}, 32'h09);

        // WIDTH = 8 boundary.
        @(negedge clk);
        in_valid8 = 1'b1;
        a8        = 8'hFF;
        b8        = 8'hFF;
        cin8      = 1'b1;
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check("w8 sum",       {24'b0, sum8},       32'hFF);
        check("w8 cout",      {31'b0, cout8},      32'h1);
        check("w8 ovf",       {31'b0, ovf8},       32'h0);
        check("w8 out_valid", {31'b0, out_valid8}, 32'h1);
        @(posedge clk);
        #1;
        check("w8 out_valid drop", {31'b0, out_valid8}, 32'h0);
        check("w8 sum hold",       {24'b0, sum8},       32'hFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ripple_carry_adder.md
Name: ripple_carry_adder

Overview:
- Parameterised ripple-carry adder, default 4 bits: {Cout, Sum} = A + B + Cin.
- Built as a chain of 1-bit full adders. The carry ripples from bit 0 to bit WIDTH-1.
- Result is registered once on clk, so results are timing-isolated from downstream logic.
- Used as the basic arithmetic leaf in datapaths and as a bring-up reference for the adder family.

Parameters:
- WIDTH, 4, operand and sum width in bits; legal range is 1 or greater.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands A/B/Cin are valid this cycle
- A  input  WIDTH  operand A, unsigned
- B  input  WIDTH  operand B, unsigned
- Cin  input  1  carry-in
- Sum  output  WIDTH  registered sum bits
- Cout  output  1  registered carry-out of the MSB
- Ovf  output  1  registered two's-complement overflow: carry into MSB XOR carry out of MSB
- out_valid  output  1  Sum/Cout/Ovf hold a new result

Behaviour:
- Combinational datapath, per bit i:
  - s[i] = A[i]^B[i]^c[i]
  - c[i+1] = A[i]&B[i] | c[i]&(A[i]^B[i])
  - c[0] = Cin
- No lookahead or carry-select; a pure ripple chain.
- Arithmetic is exact modulo 2^(WIDTH+1): {Cout, Sum} = A + B + Cin, with no saturation.
- Ovf = c[WIDTH] ^ c[WIDTH-1]. When WIDTH = 1, c[WIDTH-1] is Cin.
- Register stage, rising clk edge:
  - If in_valid = 1: Sum, Cout and Ovf capture the combinational result, and out_valid is set to 1.
  - If in_valid = 0: Sum, Cout and Ovf hold their previous values, and out_valid is set to 0.
- Latency is exactly 1 cycle from in_valid to out_valid. Throughput is one result per cycle, with no stall or backpressure.
- Reset: rst_n = 0 immediately, without waiting for clk, forces Sum = 0, Cout = 0, Ovf = 0 and out_valid = 0.
  - Deassertion is synchronised externally.
  - The first capture can occur at the first rising edge with rst_n = 1.
- Reset mid-operation: any in-flight result is discarded. The outputs stay zero until the next valid capture after release.
- Boundaries:
  - All-ones + all-ones + 1 gives Sum = all-ones, Cout = 1.
  - 0 + 0 + 0 gives all zeros.
  - All-ones + 0 + 1 gives a full-chain ripple: Sum = 0, Cout = 1.
- X on inputs while in_valid = 0 must not disturb the held outputs.

Decomposition:
- Sub-module full_adder: ports a, b, cin, s, cout, pure combinational. Instantiate WIDTH copies with a generate loop, chained through the carry vector c[WIDTH:0].
- Shared package adder_pkg: constant DEFAULT_ADDER_WIDTH = 4. It is reused by other adder variants.
- No typedefs are required.

Test Plan:
- Exhaustive at WIDTH = 4: all 512 combinations of A 0..15, B 0..15, Cin 0..1, one per cycle with in_valid = 1 → on the next cycle {Cout, Sum} = A + B + Cin and out_valid = 1. Examples:
  - A=4'b1111, B=4'b0001, Cin=0 → Sum=4'b0000, Cout=1
  - A=4'b0101, B=4'b0011, Cin=1 → Sum=4'b1001, Cout=0
- Full ripple: A=4'hF, B=4'h0, Cin=1 → Sum=4'h0, Cout=1, Ovf=0.
- Overflow: A=4'h7, B=4'h1, Cin=0 → Sum=4'h8, Cout=0, Ovf=1. A=4'h8, B=4'h8, Cin=0 → Sum=4'h0, Cout=1, Ovf=1.
- Hold: capture A=3, B=4, Cin=0 (Sum=7), then drive in_valid=0 with A=B=4'hX for 3 cycles → Sum stays 7, out_valid=0.
- Async reset: with Sum=4'hE registered, pulse rst_n low between clock edges → all outputs 0 immediately. Next valid input after release → correct result 1 cycle later.
- WIDTH=8 instance: A=8'hFF, B=8'hFF, Cin=1 → Sum=8'hFF, Cout=1.
